// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-coin vending machine.
// State encoding, default pricing and the credit-sum width helper.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam int DEFAULT_PRICE      = 10;
    localparam int DEFAULT_MAX_CREDIT = 255;

    // One extra bit so credit + coin can never wrap before the limit check.
    function automatic int sum_width(input int val_w);
        return val_w + 1;
    endfunction

endpackage

// File: rtl/vending_change_port.sv
// Valid/ready output register for the change payout.
// Loads an amount, holds it stable until accepted, then clears.
module vending_change_port #(
    parameter int VAL_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [VAL_W-1:0] amount,
    input  logic             ready,
    output logic             valid,
    output logic [VAL_W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= amount;
        end else if (valid && ready) begin
            valid <= 1'b0;
            data  <= '0;
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-coin vending FSM with credit accumulator, change payout and refund.
// Optional stock tracking is enabled by defining VENDING_STOCK_EN.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int VAL_W      = 8,
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
    parameter int STOCK_INIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin,
    input  logic [VAL_W-1:0] coin_value,
    input  logic             cancel,
    output logic             valid,
    output logic             coin_reject,
    output logic [VAL_W-1:0] credit,
    output logic             change_valid,
    output logic [VAL_W-1:0] change,
    input  logic             change_ready,
    output logic             sold_out
);

    localparam int SUM_W = sum_width(VAL_W);

    state_t           state_q, state_d;
    logic [VAL_W-1:0] credit_q, credit_d;
    logic             valid_q, reject_q, reject_d;
    logic [SUM_W-1:0] coin_sum;
    logic             coin_present;
    logic             coin_fits;
    logic             sold_q;
    logic             change_load;

    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_present = coin && (coin_value != '0);
    assign coin_fits    = (coin_sum <= SUM_W'(MAX_CREDIT));

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && state_q == COLLECT) begin
                    state_d  = REFUND;
                    reject_d = coin_present;
                end else begin
                    if (coin_present) begin
                        if (coin_fits && !sold_q) credit_d = coin_sum[VAL_W-1:0];
                        else                      reject_d = 1'b1;
                    end
                    if (credit_d >= VAL_W'(PRICE)) state_d = VEND;
                    else if (credit_d != '0)       state_d = COLLECT;
                    else                           state_d = IDLE;
                end
            end
            VEND: begin
                reject_d = coin_present;
                credit_d = credit_q - VAL_W'(PRICE);
                state_d  = (credit_q != VAL_W'(PRICE)) ? REFUND : IDLE;
            end
            REFUND: begin
                reject_d = coin_present;
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            valid_q  <= (state_d == VEND);
            reject_q <= reject_d;
        end
    end

    // Change is captured on entry to REFUND; it equals the credit held there.
    assign change_load = (state_d == REFUND) && (state_q != REFUND);

    vending_change_port #(.VAL_W(VAL_W)) u_change_port (
        .clk    (clk),
        .reset  (reset),
        .load   (change_load),
        .amount (credit_d),
        .ready  (change_ready),
        .valid  (change_valid),
        .data   (change)
    );

`ifdef VENDING_STOCK_EN
    localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [STOCK_W-1:0] stock_q, stock_d;

    always_comb begin
        stock_d = stock_q;
        if (state_q == VEND && stock_q != '0) stock_d = stock_q - STOCK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stock_q <= STOCK_W'(STOCK_INIT);
            sold_q  <= (STOCK_INIT == 0);
        end else begin
            stock_q <= stock_d;
            sold_q  <= (stock_d == '0);
        end
    end
`else
    // No stock tracking: constant low (the comparison is never true).
    assign sold_q = (STOCK_INIT < 0);
`endif

    assign valid       = valid_q;
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign sold_out    = sold_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed scenarios plus
// randomized traffic, all compared against a behavioural credit model.
module tb_vending_machine_multi;

    localparam int VAL_W      = 8;
    localparam int PRICE      = 10;
    localparam int MAX_CREDIT = 20;
    localparam int STOCK_INIT = 2;

    logic             clk = 1'b0;
    logic             reset, coin, cancel, change_ready;
    logic [VAL_W-1:0] coin_value;
    logic             valid, coin_reject, change_valid, sold_out;
    logic [VAL_W-1:0] credit, change;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: credit held, whether a sale or a payout is pending.
    int m_credit, m_change, m_stock;
    bit m_vend, m_refund, m_reject, m_sold, m_just_reset;

    vending_machine_multi #(
        .VAL_W(VAL_W), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .coin_value   (coin_value),
        .cancel       (cancel),
        .valid        (valid),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .change_valid (change_valid),
        .change       (change),
        .change_ready (change_ready),
        .sold_out     (sold_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input int v, input bit cn, input bit rd);
        bit present;
        present      = c && (v != 0);
        m_reject     = 1'b0;
        m_just_reset = 1'b0;
        if (r) begin
            m_credit = 0; m_change = 0; m_vend = 0; m_refund = 0;
            m_stock  = STOCK_INIT; m_just_reset = 1;
        end else if (m_refund) begin
            m_reject = present;
            if (rd) begin
                m_refund = 0;
                m_credit = 0;
            end
        end else if (m_vend) begin
            m_reject = present;
            m_vend   = 0;
            m_credit = m_credit - PRICE;
            if (m_stock > 0) m_stock--;
            if (m_credit > 0) begin
                m_refund = 1;
                m_change = m_credit;
            end
        end else if (cn && m_credit > 0) begin
            m_reject = present;
            m_refund = 1;
            m_change = m_credit;
        end else if (present) begin
            if (!m_sold && m_credit + v <= MAX_CREDIT) begin
                m_credit += v;
                if (m_credit >= PRICE) m_vend = 1;
            end else begin
                m_reject = 1;
            end
        end
`ifdef VENDING_STOCK_EN
        m_sold = (m_stock == 0);
`else
        m_sold = 1'b0;
`endif
    endtask

    task automatic cycle(input bit r, input bit c, input int v, input bit cn, input bit rd);
        reset        = r;
        coin         = c;
        coin_value   = VAL_W'(v);
        cancel       = cn;
        change_ready = rd;
        @(posedge clk);
        model_step(r, c, v, cn, rd);
        #1;
        check("valid", valid, m_vend);
        check("coin_reject", coin_reject, m_reject);
        check("credit", credit, m_credit);
        check("change_valid", change_valid, m_refund);
        if (m_refund || m_just_reset) check("change", change, m_change);
        check("sold_out", sold_out, m_sold);
    endtask

    task automatic idle(input bit rd);
        cycle(1'b0, 1'b0, 0, 1'b0, rd);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; coin = 1'b0; coin_value = '0; cancel = 1'b0; change_ready = 1'b0;
        m_sold = 1'b0;

        cycle(1, 1, 9, 1, 1);
        check("rst_credit", credit, 0);
        check("rst_valid", valid, 0);

        // Two 5-unit coins complete the price exactly.
        cycle(0, 1, 5, 0, 0);
        cycle(0, 1, 5, 0, 0);
        check("t1_credit", credit, 10);
        check("t1_valid", valid, 1);
        idle(0);
        check("t1_after_credit", credit, 0);
        check("t1_no_change", change_valid, 0);
        idle(0);

        // 7 + 7 overpays by 4; change held until accepted.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 7, 0, 0);
        cycle(0, 1, 7, 0, 0);
        check("t2_valid", valid, 1);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            check("t2_change_hold", change, 4);
        end
        idle(1);
        check("t2_cv_drop", change_valid, 0);
        check("t2_credit0", credit, 0);

        // Cancel refunds, and cancel beats a simultaneous coin.
        cycle(0, 1, 3, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("t3_change", change, 3);
        idle(1);
        cycle(0, 1, 4, 0, 0);
        cycle(0, 1, 5, 1, 0);
        check("t3_reject", coin_reject, 1);
        check("t3_change_pre", change, 4);
        idle(1);

        // Over-limit coin, coin in VEND, coin in REFUND, reset mid-REFUND.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 8, 0, 0);
        cycle(0, 1, 15, 0, 0);
        check("t4_over_reject", coin_reject, 1);
        check("t4_over_credit", credit, 8);
        cycle(0, 1, 6, 0, 0);
        cycle(0, 1, 1, 0, 0);
        check("t4_vend_reject", coin_reject, 1);
        idle(0);
        check("t4_refund_change", change, 4);
        cycle(0, 1, 3, 0, 0);
        check("t4_refund_reject", coin_reject, 1);
        cycle(1, 0, 0, 0, 0);
        check("t4_rst_cv", change_valid, 0);
        check("t4_rst_change", change, 0);
        cycle(0, 1, 10, 0, 0);
        check("t4_post_rst_valid", valid, 1);
        idle(0);

        // Continuous 5-unit coins: one sale every three cycles.
        cycle(1, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 5, 0, 0);
            if (valid) pulses++;
        end
`ifdef VENDING_STOCK_EN
        check("t5_pulses", pulses, 2);
`else
        check("t5_pulses", pulses, 3);
`endif
        idle(0);

`ifdef VENDING_STOCK_EN
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 10, 0, 0); idle(0);
        cycle(0, 1, 10, 0, 0); idle(0);
        check("t6_sold_out", sold_out, 1);
        cycle(0, 1, 5, 0, 0);
        check("t6_reject", coin_reject, 1);
        idle(0);
        check("t6_no_valid", valid, 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 1), ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 12)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
